// File: rtl/pattern_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pattern_writer                                                  |
// | Brief    : Debounced store/clear front end that records switch patterns    |
// |            into a 16-entry pattern memory through a write port.            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module pattern_writer #(
    parameter int DB_CYCLES = 250000,
    parameter int DEPTH     = 16,
    parameter int WIDTH     = 5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         sw,
    input  logic                     store,
    input  logic                     clear,
    output logic                     wr_en,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     busy
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CW    = c_AW + 1;
    localparam int c_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DB_CYCLES - 1);
    localparam logic [c_CW-1:0]    c_LAST    = c_CW'(DEPTH - 1);

    localparam int c_ST_W = 1;
    localparam logic [c_ST_W-1:0] c_ST_IDLE  = 1'b0;
    localparam logic [c_ST_W-1:0] c_ST_CLEAR = 1'b1;

    // Button index 0 is store, 1 is clear.
    logic [1:0]       w_btn_raw;
    logic [1:0]       w_press;
    logic [WIDTH-1:0] r_sw_s1;
    logic [WIDTH-1:0] r_sw_s2;

    assign w_btn_raw = {clear, store};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic               r_s1;
        logic               r_s2;
        logic               r_db;
        logic               r_db_prev;
        logic [c_CNT_W-1:0] r_cnt;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_s1      <= 1'b0;
                r_s2      <= 1'b0;
                r_db      <= 1'b0;
                r_db_prev <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_s1      <= w_btn_raw[i];
                r_s2      <= r_s1;
                r_db_prev <= r_db;
                if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_db  <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_press[i] = r_db & ~r_db_prev;
    end

    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_nxt;
    logic [c_AW-1:0]   r_ptr;
    logic [c_CW-1:0]   r_clr_addr;
    logic [c_CW-1:0]   r_count;
    logic              r_full;
    logic              r_busy;
    logic              r_wr_en;
    logic [c_AW-1:0]   r_wr_addr;
    logic [WIDTH-1:0]  r_wr_data;

    logic [c_AW-1:0]   w_ptr_nxt;
    logic [c_CW-1:0]   w_clr_addr_nxt;
    logic [c_CW-1:0]   w_count_nxt;
    logic              w_full_nxt;
    logic              w_busy_nxt;
    logic              w_wr_en_nxt;
    logic [c_AW-1:0]   w_wr_addr_nxt;
    logic [WIDTH-1:0]  w_wr_data_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The clear walker runs one past the last address so that busy drops
    // together with the final write strobe rather than during it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_press[1]) w_state_nxt = c_ST_CLEAR;
            c_ST_CLEAR: if (r_clr_addr[c_AW]) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt      = r_ptr;
        w_clr_addr_nxt = r_clr_addr;
        w_count_nxt    = r_count;
        w_full_nxt     = r_full;
        w_busy_nxt     = r_busy;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        case (r_state)
            c_ST_IDLE: begin
                if (w_press[1]) begin
                    w_clr_addr_nxt = '0;
                    w_busy_nxt     = 1'b1;
                end else if (w_press[0] && !r_full) begin
                    w_wr_en_nxt   = 1'b1;
                    w_wr_addr_nxt = r_ptr;
                    w_wr_data_nxt = r_sw_s2;
                    w_ptr_nxt     = r_ptr + 1'b1;
                    w_count_nxt   = r_count + 1'b1;
                    w_full_nxt    = (r_count == c_LAST);
                end
            end
            c_ST_CLEAR: begin
                if (r_clr_addr[c_AW]) begin
                    w_ptr_nxt   = '0;
                    w_count_nxt = '0;
                    w_full_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_wr_en_nxt    = 1'b1;
                    w_wr_addr_nxt  = r_clr_addr[c_AW-1:0];
                    w_wr_data_nxt  = '0;
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr      <= '0;
            r_clr_addr <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_busy     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_ptr      <= w_ptr_nxt;
            r_clr_addr <= w_clr_addr_nxt;
            r_count    <= w_count_nxt;
            r_full     <= w_full_nxt;
            r_busy     <= w_busy_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wr_addr  <= w_wr_addr_nxt;
            r_wr_data  <= w_wr_data_nxt;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign count   = r_count;
    assign full    = r_full;
    assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pattern_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pattern_writer                                               |
// | Brief    : Directed/random bench for pattern_writer with a write-list model.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+

module tb_pattern_writer;

    localparam int c_DB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] sw    = '0;
    logic       store = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [4:0] wr_data;
    logic [4:0] count;
    logic       full;
    logic       busy;

    pattern_writer #(
        .DB_CYCLES (c_DB),
        .DEPTH     (16),
        .WIDTH     (5)
    ) u_dut (
        .clock   (clock),
        .reset   (reset),
        .sw      (sw),
        .store   (store),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .full    (full),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Observed writes as {addr, data}, and the model's expected writes.
    logic [8:0] wq[$];
    logic [8:0] exp_q[$];
    int         m_count;
    int         m_ptr;

    always @(negedge clock) begin
        if (reset === 1'b0 && wr_en === 1'b1) wq.push_back({wr_addr, wr_data});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_store(input logic [4:0] d);
        if (m_count < 16) begin
            exp_q.push_back({4'(m_ptr), d});
            m_ptr   = (m_ptr + 1) % 16;
            m_count = m_count + 1;
        end
    endfunction

    function automatic void model_clear();
        for (int a = 0; a < 16; a++) exp_q.push_back({4'(a), 5'd0});
        m_ptr   = 0;
        m_count = 0;
    endfunction

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, wq.size(), exp_q.size());
        for (int k = 0; k < wq.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_wr%0d", tag, k), {23'd0, wq[k]}, {23'd0, exp_q[k]});
        chk({tag, "_count"}, {27'd0, count}, m_count);
        chk({tag, "_full"}, {31'd0, full}, {31'd0, m_count == 16});
        wq.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        store = 1'b0;
        clear = 1'b0;
        sw    = '0;
        cyc(2);
        reset = 1'b0;
        m_count = 0;
        m_ptr   = 0;
        wq.delete();
        exp_q.delete();
    endtask

    task automatic press_store(input logic [4:0] d, input int hold);
        sw    = d;
        store = 1'b1;
        cyc(hold);
        store = 1'b0;
        cyc(8);
        model_store(d);
    endtask

    initial begin
        logic [4:0] d;
        cyc(1);
        do_reset();
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 0);
        chk("rst_wr_data", {27'd0, wr_data}, 0);
        chk("rst_count", {27'd0, count}, 0);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_busy", {31'd0, busy}, 0);

        // Store latency: raw store seen at E0, write strobe in the cycle after E6.
        sw    = 5'b10101;
        store = 1'b1;
        cyc(6);
        chk("lat_pre", {31'd0, wr_en}, 0);
        cyc(1);
        chk("lat_wr_en", {31'd0, wr_en}, 1);
        chk("lat_addr", {28'd0, wr_addr}, 0);
        chk("lat_data", {27'd0, wr_data}, 32'b10101);
        chk("lat_count", {27'd0, count}, 1);
        chk("lat_full", {31'd0, full}, 0);
        cyc(1);
        chk("lat_post", {31'd0, wr_en}, 0);
        cyc(2);
        store = 1'b0;
        cyc(8);
        chk("hold_one_write", wq.size(), 1);
        chk("hold_data_kept", {27'd0, wr_data}, 32'b10101);

        // Fill all 16 entries, then a 17th press must be ignored.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            press_store(5'(i), $urandom_range(4, 12));
            check_writes($sformatf("fill%0d", i));
        end
        press_store(5'($urandom), 6);
        check_writes("overfill");

        // Random stores, short glitches, then a checked clear sequence.
        do_reset();
        for (int i = 0; i < 5; i++) press_store(5'($urandom), $urandom_range(4, 10));
        check_writes("pre_clear");
        for (int g = 1; g <= 3; g++) begin
            sw    = 5'($urandom);
            store = 1'b1;
            cyc(g);
            store = 1'b0;
            cyc(8);
        end
        check_writes("glitch");
        clear = 1'b1;
        cyc(6);
        clear = 1'b0;
        cyc(1);
        chk("clr_busy_rise", {31'd0, busy}, 1);
        chk("clr_no_wr_yet", {31'd0, wr_en}, 0);
        for (int a = 0; a < 16; a++) begin
            cyc(1);
            chk($sformatf("clr_wr_en%0d", a), {31'd0, wr_en}, 1);
            chk($sformatf("clr_addr%0d", a), {28'd0, wr_addr}, a);
            chk($sformatf("clr_data%0d", a), {27'd0, wr_data}, 0);
            chk($sformatf("clr_busy%0d", a), {31'd0, busy}, 1);
        end
        cyc(1);
        chk("clr_end_wr_en", {31'd0, wr_en}, 0);
        chk("clr_end_busy", {31'd0, busy}, 0);
        model_clear();
        cyc(2);
        check_writes("clear");
        d = 5'($urandom);
        press_store(d, 5);
        check_writes("after_clear");

        // Simultaneous store and clear: clear wins, store is dropped.
        press_store(5'($urandom), 5);
        check_writes("pre_both");
        sw    = 5'($urandom) | 5'b00001;
        store = 1'b1;
        clear = 1'b1;
        cyc(6);
        store = 1'b0;
        clear = 1'b0;
        cyc(24);
        model_clear();
        check_writes("both");
        chk("both_busy", {31'd0, busy}, 0);

        // Store pressed while clearing is ignored.
        press_store(5'($urandom), 6);
        check_writes("pre_clr_store");
        clear = 1'b1;
        cyc(6);
        clear = 1'b0;
        cyc(2);
        sw    = 5'($urandom) | 5'b10000;
        store = 1'b1;
        cyc(6);
        store = 1'b0;
        cyc(16);
        model_clear();
        check_writes("store_in_clear");
        chk("store_in_clear_busy", {31'd0, busy}, 0);

        // Reset during the 8th clear write aborts the sequence.
        do_reset();
        for (int i = 0; i < 3; i++) press_store(5'($urandom), 6);
        check_writes("pre_abort");
        clear = 1'b1;
        cyc(6);
        clear = 1'b0;
        cyc(1);
        chk("abort_busy", {31'd0, busy}, 1);
        cyc(8);
        chk("abort_8th_wr", {31'd0, wr_en}, 1);
        chk("abort_8th_addr", {28'd0, wr_addr}, 7);
        reset = 1'b1;
        cyc(1);
        chk("abort_wr_en", {31'd0, wr_en}, 0);
        chk("abort_busy_low", {31'd0, busy}, 0);
        chk("abort_count", {27'd0, count}, 0);
        reset = 1'b0;
        m_count = 0;
        m_ptr   = 0;
        cyc(2);
        wq.delete();
        exp_q.delete();
        press_store(5'($urandom), 7);
        check_writes("after_abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pattern_writer.md
# pattern_writer

Record-side counterpart to the LED pattern player: captures 5-bit patterns from slide switches on a debounced "store" button press and writes them sequentially into the 16-entry pattern memory through a write port. The pattern memory feeds the program-counter-driven LED playback path. A debounced "clear" button zero-fills the memory and rewinds the write pointer. Runs on the fast board clock; debounce is in clock cycles.

## Interface
- DB_CYCLES, default 250000: consecutive stable synchronized samples required before a button level change is accepted (bench uses 4).
- DEPTH, fixed 16: pattern memory entries; address width 4.
- WIDTH, fixed 5: pattern width, matches LED count.

- clock  in  1  board clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- sw  in  5  raw switch pattern, asynchronous.
- store  in  1  raw store button, asynchronous, active-high.
- clear  in  1  raw clear button, asynchronous, active-high.
- wr_en  out  1  memory write strobe, one cycle per write.
- wr_addr  out  4  memory write address.
- wr_data  out  5  memory write data.
- count  out  5  number of patterns stored, 0..16.
- full  out  1  count == 16.
- busy  out  1  clear sequence in progress.

## Operation
- Synchronizers: sw, store, clear each pass through two flops (s1, s2).
- Debouncer per button: level register db, counter. Each edge: if s2 == db, counter <= 0; else counter increments; when counter reaches DB_CYCLES-1 while s2 still differs, db <= s2 and counter <= 0. Counter width ceil(log2(DB_CYCLES)).
- Press pulse = db & ~db_prev (db_prev registered), one cycle per accepted rising level. Releases produce no pulse.
- FSM states: IDLE, CLEAR.
- IDLE, clear pulse: go CLEAR, clr_addr <= 0, busy <= 1. Clear pulse takes priority over a simultaneous store pulse (store dropped).
- IDLE, store pulse, full = 0: wr_en <= 1, wr_addr <= ptr, wr_data <= synchronized sw (s2 value at pulse edge), ptr <= ptr+1 (4-bit wrap to 0 after 15), count <= count+1, full <= (count == 15).
- IDLE, store pulse, full = 1: ignored; no write, no state change.
- CLEAR: each cycle wr_en <= 1, wr_addr <= clr_addr, wr_data <= 0, clr_addr++. After writing address 15: ptr <= 0, count <= 0, full <= 0, busy <= 0, back to IDLE. Exactly 16 writes, addresses 0..15 in order.
- Store or clear pulses during CLEAR are ignored (debouncers keep running).
- wr_en is 0 in every cycle not listed above; wr_addr/wr_data hold last written values when wr_en = 0.

## Timing
- Reset values: wr_en 0, wr_addr 0, wr_data 0, count 0, full 0, busy 0; ptr 0, FSM IDLE, all sync/debounce flops and counters 0.
- Reset in CLEAR: aborts immediately to reset values; memory partially cleared, which is accepted.
- All outputs registered.
- Store latency: with store raw high and stable from edge E0, wr_en is high for the single cycle following edge E(DB_CYCLES+2).
- Clear latency: busy rises after edge E(DB_CYCLES+2); 16 consecutive wr_en cycles; busy falls and count = 0 after the edge that ends the 16th write cycle.
- Glitch shorter than DB_CYCLES synchronized cycles: no pulse, no write.
- Holding store produces exactly one write per press.

## Test plan
- Reset, then press store (held 10 cycles, DB_CYCLES=4) with sw=5'b10101 -> one wr_en pulse, wr_addr 0, wr_data 10101, at E6; count 1, full 0.
- 16 presses with sw = press index -> writes to addresses 0..15, data 0..15, count 16, full 1; 17th press -> no wr_en, count stays 16.
- Store glitch high for 3 synchronized cycles -> no wr_en, count unchanged.
- After 5 stores, press clear -> busy 1, 16 writes of 0 to addresses 0..15, then count 0, full 0, busy 0; next store writes address 0.
- Store and clear pressed on same edge -> clear sequence only, no pattern write; store pressed during CLEAR -> ignored.
- Assert reset during clear at 8th write -> next cycle wr_en 0, busy 0, count 0; following store writes address 0.
